led_seq_ctrl: RTL and testbench

Sequencer for the 16-bit LED rotation register on the board. It owns the step prescaler, the run/pause/stop state machine, step counting and direction control. It produces the LED vector directly plus a one-cycle step strobe. Rotate left, rotate right, bounce and blink modes are selected at start time.

---
 rtl/led_seq_pkg.sv | 8 +
 rtl/led_seq_ctrl_step_prescaler.sv | 23 ++
 rtl/led_seq_ctrl.sv | 102 ++++++++++
 tb/tb_led_seq_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: state and mode encodings shared by the LED sequencer.
package led_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
    localparam logic [1:0] MODE_ROTL   = 2'b00;
    localparam logic [1:0] MODE_ROTR   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;
endpackage

// File: rtl/led_seq_ctrl_step_prescaler.sv
// step_prescaler: step-rate divider; tick flags the terminal count (DIV<<speed)-1,
// the counter only moves while en is high and wraps to 0 on the terminal count.
module step_prescaler #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick
);
    localparam int CW = $clog2(DIV << 3);
    logic [CW-1:0] cnt;
    logic [CW-1:0] term;
    assign term = CW'((DIV << speed) - 1);
    assign tick = cnt == term;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: run/pause/stop sequencer driving the LED rotation register,
// with rotate, bounce and blink step patterns and an optional step budget.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int               WIDTH         = 16,
    parameter int               CLK_HZ        = 100000000,
    parameter int               STEP_HZ       = 32,
    parameter logic [WIDTH-1:0] RESET_PATTERN = 16'hFFFE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic [7:0]       steps,
    input  logic             pattern_load,
    input  logic [WIDTH-1:0] pattern_in,
    output logic [WIDTH-1:0] led,
    output logic             step_tick,
    output logic             busy,
    output logic             done
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = $clog2(WIDTH);
    state_t state, nxt;
    logic [1:0] mode_l, speed_l;
    logic [7:0] steps_l, step_cnt;
    logic [PW-1:0] pos, pos_nxt;
    logic dir;
    logic idle, accept, load, tick, adv, last;
    logic [WIDTH-1:0] rotl, rotr, led_nxt;
    assign idle    = state == IDLE || state == DONE;
    assign busy    = state == RUN || state == HOLD;
    assign accept  = idle && start && !stop && !pattern_load;
    assign load    = idle && pattern_load && !stop;
    assign adv     = state == RUN && tick && !stop;
    assign last    = step_tick && steps_l != 8'd0 && step_cnt == steps_l;
    assign rotl    = {led[WIDTH-2:0], led[WIDTH-1]};
    assign rotr    = {led[0], led[WIDTH-1:1]};
    assign pos_nxt = dir ? pos - 1'b1 : pos + 1'b1;
    assign led_nxt = mode_l == MODE_ROTL  ? rotl :
                     mode_l == MODE_ROTR  ? rotr :
                     mode_l == MODE_BLINK ? ~led :
                     dir ? rotr : rotl;
    // a pause on the terminal-count cycle still lets that step wrap the prescaler
    step_prescaler #(.DIV(DIV)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (state == RUN && (!pause || tick)),
        .clr  (accept || stop),
        .speed(speed_l),
        .tick (tick)
    );
    always_comb begin
        nxt = state;
        if (stop) nxt = IDLE;
        else if (accept) nxt = RUN;
        else if (busy && last) nxt = DONE;
        else if (state == RUN && pause) nxt = HOLD;
        else if (state == HOLD && !pause) nxt = RUN;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= nxt;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led       <= RESET_PATTERN;
            mode_l    <= MODE_ROTL;
            speed_l   <= '0;
            steps_l   <= '0;
            step_cnt  <= '0;
            pos       <= '0;
            dir       <= 1'b0;
            step_tick <= 1'b0;
            done      <= 1'b0;
        end else begin
            step_tick <= adv;
            done      <= busy && nxt == DONE;
            if (load) led <= pattern_in;
            if (accept) begin
                mode_l   <= mode;
                speed_l  <= speed;
                steps_l  <= steps;
                step_cnt <= '0;
                pos      <= '0;
                dir      <= 1'b0;
            end else if (adv) begin
                led      <= led_nxt;
                step_cnt <= step_cnt + 1'b1;
                if (mode_l == MODE_BOUNCE) begin
                    pos <= pos_nxt;
                    if (pos_nxt == PW'(WIDTH - 1)) dir <= 1'b1;
                    else if (pos_nxt == '0) dir <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed scoreboard bench for led_seq_ctrl with DIV=4.
module tb_led_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0, stop = 1'b0, pause = 1'b0, pattern_load = 1'b0;
    logic [1:0]  mode = 2'b00, speed = 2'b00;
    logic [7:0]  steps = 8'd0;
    logic [15:0] pattern_in = 16'h0;
    logic [15:0] led;
    logic        step_tick, busy, done;
    int n_cmp = 0, n_err = 0, cyc = 0;

    typedef struct {
        bit          is_done;
        logic [15:0] led;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    led_seq_ctrl #(.CLK_HZ(8), .STEP_HZ(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .mode        (mode),
        .speed       (speed),
        .steps       (steps),
        .pattern_load(pattern_load),
        .pattern_in  (pattern_in),
        .led         (led),
        .step_tick   (step_tick),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit is_done, input logic [15:0] l, input int c);
        exp_t e;
        e.is_done = is_done;
        e.led = l;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // monitor: every tick or done pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst && (step_tick || done)) begin
            if (sb.size() == 0) chk("unexpected_event", {30'd0, step_tick, done}, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.is_done ? "done_cycle" : "tick_cycle", cyc, e.cyc);
                chk(e.is_done ? "done_flags" : "tick_flags", {30'd0, step_tick, done},
                    e.is_done ? 32'd1 : 32'd2);
                if (!e.is_done) chk("tick_led", {16'd0, led}, {16'd0, e.led});
            end
        end
    end

    task automatic start_seq(input logic [1:0] m, input logic [1:0] s, input logic [7:0] n,
                             output int a);
        @(negedge clk);
        start = 1'b1;
        mode = m;
        speed = s;
        steps = n;
        a = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load(input logic [15:0] p);
        @(negedge clk);
        pattern_load = 1'b1;
        pattern_in = p;
        @(negedge clk);
        pattern_load = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int i;
        for (i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("scoreboard_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_led", {16'd0, led}, 32'hFFFE);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_tick", {31'd0, step_tick}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b1;

        // rotate left, three steps
        start_seq(2'b00, 2'b00, 8'd3, a);
        push(0, 16'hFFFD, a + 4);
        push(0, 16'hFFFB, a + 8);
        push(0, 16'hFFF7, a + 12);
        push(1, 16'h0, a + 13);
        wait_empty(40);
        @(negedge clk);
        chk("rotl_busy_after", {31'd0, busy}, 32'd0);
        chk("rotl_led_after", {16'd0, led}, 32'hFFF7);

        // rotate right at speed 2
        load(16'h0001);
        chk("load_in_done", {16'd0, led}, 32'h0001);
        start_seq(2'b01, 2'b10, 8'd2, a);
        push(0, 16'h8000, a + 16);
        push(0, 16'h4000, a + 32);
        push(1, 16'h0, a + 33);
        wait_empty(80);

        // bounce: full 30-step period, then stop
        load(16'h0001);
        start_seq(2'b10, 2'b00, 8'd0, a);
        for (int k = 1; k <= 30; k++)
            push(0, k <= 15 ? 16'(1 << k) : 16'(1 << (30 - k)), a + 4 * k);
        wait_empty(200);
        pulse_stop();
        chk("bounce_stop_busy", {31'd0, busy}, 32'd0);
        chk("bounce_stop_led", {16'd0, led}, 32'h0001);
        repeat (10) @(negedge clk);
        chk("bounce_led_held", {16'd0, led}, 32'h0001);

        // blink with a 10-cycle pause right after the first tick
        load(16'h00FF);
        start_seq(2'b11, 2'b00, 8'd0, a);
        push(0, 16'hFF00, a + 4);
        push(0, 16'h00FF, a + 19);
        push(0, 16'hFF00, a + 23);
        repeat (4) @(negedge clk);
        pause = 1'b1;
        repeat (5) @(negedge clk);
        chk("hold_busy", {31'd0, busy}, 32'd0 + 1);
        chk("hold_led", {16'd0, led}, 32'hFF00);
        repeat (5) @(negedge clk);
        pause = 1'b0;
        wait_empty(40);
        pulse_stop();

        // collisions: start and load while busy are ignored
        load(16'h0003);
        start_seq(2'b00, 2'b00, 8'd2, a);
        push(0, 16'h0006, a + 4);
        push(0, 16'h000C, a + 8);
        push(1, 16'h0, a + 9);
        @(negedge clk);
        start = 1'b1;
        mode = 2'b01;
        steps = 8'd0;
        pattern_load = 1'b1;
        pattern_in = 16'hAAAA;
        @(negedge clk);
        start = 1'b0;
        pattern_load = 1'b0;
        chk("busy_load_ignored", {16'd0, led}, 32'h0003);
        wait_empty(40);
        @(negedge clk);
        chk("collide_done_idle", {31'd0, busy}, 32'd0);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            stop = 1'b1;
            start = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            start = 1'b0;
            chk("stop_start_idle", {31'd0, busy}, 32'd0);
        end
        @(negedge clk);
        pattern_load = 1'b1;
        pattern_in = 16'h1234;
        start = 1'b1;
        mode = 2'b00;
        steps = 8'd0;
        @(negedge clk);
        pattern_load = 1'b0;
        start = 1'b0;
        chk("load_start_led", {16'd0, led}, 32'h1234);
        chk("load_start_busy", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clk);
        chk("load_start_still_idle", {31'd0, busy}, 32'd0);

        // async reset between edges at step 5
        start_seq(2'b00, 2'b00, 8'd0, a);
        push(0, 16'h2468, a + 4);
        push(0, 16'h48D0, a + 8);
        push(0, 16'h91A0, a + 12);
        push(0, 16'h2341, a + 16);
        push(0, 16'h4682, a + 20);
        for (int i = 0; i < 60 && cyc != a + 20; i++) @(negedge clk);
        chk("reach_step5", cyc, a + 20);
        #2 rst = 1'b0;
        #1;
        chk("async_led", {16'd0, led}, 32'hFFFE);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_tick", {31'd0, step_tick}, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_led", {16'd0, led}, 32'hFFFE);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
